// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product, WIDTH+1 cycles per multiply.
// Define SIGNED_MULT_EN for two's-complement operands; the default build is unsigned.
module shift_add_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               pronto,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_h;
    logic [WIDTH-1:0]   r_l;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_pronto;
    logic [2*WIDTH-1:0] r_p;

    logic               w_last;
    logic [WIDTH:0]     w_s;
    logic [WIDTH-1:0]   w_h_nxt;
    logic [WIDTH-1:0]   w_l_nxt;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // One partial-product step; s keeps the carry (or sign) in bit WIDTH.
    always_comb begin
        w_s = {1'b0, r_h};
`ifdef SIGNED_MULT_EN
        // The multiplier's sign bit carries negative weight, hence the subtract on the last step.
        if (r_l[0]) begin
            if (w_last) begin
                w_s = {r_h[WIDTH-1], r_h} - {r_x[WIDTH-1], r_x};
            end else begin
                w_s = {r_h[WIDTH-1], r_h} + {r_x[WIDTH-1], r_x};
            end
        end else begin
            w_s = {r_h[WIDTH-1], r_h};
        end
`else
        if (r_l[0]) begin
            w_s = {1'b0, r_h} + {1'b0, r_x};
        end else begin
            w_s = {1'b0, r_h};
        end
`endif
        w_h_nxt = w_s[WIDTH:1];
        w_l_nxt = {w_s[0], r_l[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; p is loaded only when DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_h      <= '0;
            r_l      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_pronto <= 1'b0;
            r_p      <= '0;
        end else begin
            r_pronto <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x     <= a;
                        r_l     <= b;
                        r_h     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_h <= w_h_nxt;
                    r_l <= w_l_nxt;
                    if (w_last) begin
                        r_p      <= {w_h_nxt, w_l_nxt};
                        r_pronto <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign pronto = r_pronto;
    assign p      = r_p;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Scoreboard bench for shift_add_mult_seq (WIDTH=8): driver pushes expected products, monitor pops on pronto.
module tb_shift_add_mult_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           pronto;
    logic [2*W-1:0] p;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_p;

    shift_add_mult_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .pronto (pronto),
        .p      (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain arithmetic.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] ia, input logic [W-1:0] ib);
`ifdef SIGNED_MULT_EN
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{ia[W-1]}}, ia};
        sb = {{W{ib[W-1]}}, ib};
        return sa * sb;
`else
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        ua = {{W{1'b0}}, ia};
        ub = {{W{1'b0}}, ib};
        return ua * ub;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pronto pulse must match the oldest outstanding expected product.
    always @(negedge clk) begin
        if (!rst && pronto) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pronto actual=%0h expected=none at %0t", p, $time);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                if (p !== e) begin
                    errors++;
                    $display("FAIL product actual=%0h expected=%0h at %0t", p, e, $time);
                end
            end
        end
    end

    // One multiply with cycle-exact busy/pronto/held-p checks; optional ignored re-start during CALC.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2*W-1:0] exp, input bit repulse);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        exp_q.push_back(exp);
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            start = (repulse && i == 3);
            if (repulse && i == 3) begin
                a = 8'd2;
                b = 8'd2;
            end
            chk("busy_op", {31'd0, busy}, 32'd1);
            chk("pronto_timing", {31'd0, pronto}, (i == W + 1) ? 32'd1 : 32'd0);
            if (i <= W) chk("p_held", {16'd0, p}, {16'd0, last_p});
        end
        last_p = exp;
        @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("pronto_idle", {31'd0, pronto}, 32'd0);
        chk("p_hold_idle", {16'd0, p}, {16'd0, last_p});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        last_p = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pronto", {31'd0, pronto}, 32'd0);
        chk("rst_p", {16'd0, p}, 32'd0);
        rst = 1'b0;

`ifdef SIGNED_MULT_EN
        run_op(8'hFD, 8'd5, 16'hFFF1, 1'b0);
        run_op(8'h80, 8'h80, 16'h4000, 1'b0);
        run_op(8'd127, 8'hFF, 16'hFF81, 1'b0);
        run_op(8'hFF, 8'hFF, 16'h0001, 1'b0);
`else
        run_op(8'd13, 8'd11, 16'd143, 1'b0);
        run_op(8'd255, 8'd255, 16'hFE01, 1'b0);
`endif
        run_op(8'd0, 8'd200, 16'd0, 1'b0);
        run_op(8'd7, 8'd0, 16'd0, 1'b0);
        run_op(8'd13, 8'd11, 16'd143, 1'b1);

        // start held high: second product accepted on the IDLE cycle after DONE
        @(negedge clk);
        a = 8'd9;
        b = 8'd6;
        start = 1'b1;
        exp_q.push_back(ref_prod(8'd9, 8'd6));
        for (int i = 1; i <= 2 * W + 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 8'd200;
                b = 8'd3;
                exp_q.push_back(ref_prod(8'd200, 8'd3));
            end
            if (i == W + 3) start = 1'b0;
            chk("b2b_pronto", {31'd0, pronto}, (i == W + 1 || i == 2 * W + 3) ? 32'd1 : 32'd0);
            chk("b2b_busy", {31'd0, busy}, (i == W + 2 || i == 2 * W + 4) ? 32'd0 : 32'd1);
        end
        last_p = ref_prod(8'd200, 8'd3);

        // reset mid-CALC aborts the multiply
        @(negedge clk);
        a = 8'd50;
        b = 8'd60;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_pronto", {31'd0, pronto}, 32'd0);
        chk("midrst_p", {16'd0, p}, 32'd0);
        rst = 1'b0;
        last_p = '0;
        run_op(8'd21, 8'd3, ref_prod(8'd21, 8'd3), 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ra, rb, ref_prod(ra, rb), 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
